// File: rtl/msrv32_pkg.sv
// msrv32_pkg: shared encodings, FSM state type and defaults for the msrv32 write-back stage
package msrv32_pkg;
   localparam int DEF_XLEN       = 32;
   localparam int DEF_REG_ADDR_W = 5;

   localparam logic [2:0] WB_SEL_ALU  = 3'd0;
   localparam logic [2:0] WB_SEL_LOAD = 3'd1;
   localparam logic [2:0] WB_SEL_IMM  = 3'd2;
   localparam logic [2:0] WB_SEL_CSR  = 3'd3;
   localparam logic [2:0] WB_SEL_PC4  = 3'd4;

   localparam logic [1:0] LOAD_SIZE_BYTE = 2'b00;
   localparam logic [1:0] LOAD_SIZE_HALF = 2'b01;
   localparam logic [1:0] LOAD_SIZE_WORD = 2'b10;

   typedef enum logic {IDLE, WAIT_LOAD} wb_state_e;

   // Half on an odd byte, or word (size 1x) on any non-zero offset, cannot be served
   function automatic logic load_misaligned(input logic [1:0] size, input logic [1:0] addr);
      return (size == LOAD_SIZE_HALF && addr[0]) || (size[1] && addr != 2'b00);
   endfunction
endpackage

// File: rtl/msrv32_load_align.sv
// msrv32_load_align: extracts byte/half/word from an aligned memory word and sign/zero extends it
module msrv32_load_align
   import msrv32_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) (
   input  logic [XLEN-1:0] rdata_i,
   input  logic [1:0]      addr_i,
   input  logic [1:0]      size_i,
   input  logic            uns_i,
   output logic [XLEN-1:0] data_o
);
   logic [XLEN-1:0] sh;

   assign sh = rdata_i >> {addr_i, 3'b000};

   // Aligned halves always have addr[0]=0, so one byte-granular shift serves both sizes
   always_comb
      data_o = size_i == LOAD_SIZE_BYTE ? {{(XLEN-8){~uns_i & sh[7]}}, sh[7:0]} :
               size_i == LOAD_SIZE_HALF ? {{(XLEN-16){~uns_i & sh[15]}}, sh[15:0]} : rdata_i;
endmodule

// File: rtl/msrv32_wb_stage.sv
// msrv32_wb_stage: registers retiring results, selects write-back source and waits for load data
module msrv32_wb_stage
   import msrv32_pkg::*;
#(
   parameter int XLEN       = DEF_XLEN,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
   input  logic                  ms_riscv32_mp_clk_in,
   input  logic                  ms_riscv32_mp_rst_in,
   input  logic                  ex_valid_in,
   output logic                  ex_ready_out,
   input  logic [2:0]            wb_mux_sel_in,
   input  logic [XLEN-1:0]       alu_result_in,
   input  logic [XLEN-1:0]       imm_in,
   input  logic [XLEN-1:0]       csr_data_in,
   input  logic [XLEN-1:0]       pc_plus_4_in,
   input  logic [REG_ADDR_W-1:0] rd_addr_in,
   input  logic                  rf_wr_en_in,
   input  logic [1:0]            load_size_in,
   input  logic                  load_unsigned_in,
   input  logic [XLEN-1:0]       dmem_rdata_in,
   input  logic                  dmem_rvalid_in,
   output logic [XLEN-1:0]       rd_out,
   output logic [REG_ADDR_W-1:0] rd_addr_out,
   output logic                  wr_en_out,
   output logic                  stall_out,
   output logic                  load_misaligned_out
);
   wb_state_e             state_q;
   logic [XLEN-1:0]       rd_q;
   logic [REG_ADDR_W-1:0] rd_addr_q;
   logic                  wr_en_q;
   logic                  mis_q;
   logic [1:0]            addr_q;
   logic [1:0]            size_q;
   logic                  uns_q;
   logic [REG_ADDR_W-1:0] ld_rd_q;
   logic                  ld_we_q;
   logic [XLEN-1:0]       wb_data_d;
   logic [XLEN-1:0]       ld_data_d;
   logic                  capture;
   logic                  is_load;
   logic                  we;

   assign ex_ready_out        = state_q == IDLE;
   assign stall_out           = ~ex_ready_out;
   assign capture             = ex_valid_in && ex_ready_out;
   assign is_load             = wb_mux_sel_in == WB_SEL_LOAD;
   assign we                  = rf_wr_en_in && |rd_addr_in;
   assign rd_out              = rd_q;
   assign rd_addr_out         = rd_addr_q;
   assign wr_en_out           = wr_en_q;
   assign load_misaligned_out = mis_q;

   // Non-load source select; unassigned encodings fall back to the ALU result
   always_comb
      wb_data_d = wb_mux_sel_in == WB_SEL_IMM ? imm_in :
                  wb_mux_sel_in == WB_SEL_CSR ? csr_data_in :
                  wb_mux_sel_in == WB_SEL_PC4 ? pc_plus_4_in : alu_result_in;

   msrv32_load_align #(.XLEN(XLEN)) u_align (
      .rdata_i (dmem_rdata_in),
      .addr_i  (addr_q),
      .size_i  (size_q),
      .uns_i   (uns_q),
      .data_o  (ld_data_d)
   );

   // FSM with registered outputs; write data/address only move when a write retires
   always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in)
      if (ms_riscv32_mp_rst_in) begin
         state_q   <= IDLE;
         rd_q      <= '0;
         rd_addr_q <= '0;
         wr_en_q   <= 1'b0;
         mis_q     <= 1'b0;
         addr_q    <= '0;
         size_q    <= '0;
         uns_q     <= 1'b0;
         ld_rd_q   <= '0;
         ld_we_q   <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         mis_q   <= 1'b0;
         if (state_q == WAIT_LOAD) begin
            if (dmem_rvalid_in) begin
               state_q <= IDLE;
               wr_en_q <= ld_we_q;
               if (ld_we_q) begin
                  rd_q      <= ld_data_d;
                  rd_addr_q <= ld_rd_q;
               end
            end
         end else if (capture) begin
            addr_q  <= alu_result_in[1:0];
            size_q  <= load_size_in;
            uns_q   <= load_unsigned_in;
            ld_rd_q <= rd_addr_in;
            ld_we_q <= we;
            if (!is_load) begin
               wr_en_q <= we;
               if (we) begin
                  rd_q      <= wb_data_d;
                  rd_addr_q <= rd_addr_in;
               end
            end else if (load_misaligned(load_size_in, alu_result_in[1:0]))
               mis_q <= 1'b1;
            else
               state_q <= WAIT_LOAD;
         end
      end
endmodule

// File: tb/tb_msrv32_wb_stage.sv
// tb_msrv32_wb_stage: scoreboard bench for the msrv32 write-back stage
module tb_msrv32_wb_stage;
   import msrv32_pkg::*;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  addr;
   } wr_t;

   logic        clk;
   logic        rst;
   logic        ex_valid_in;
   logic        ex_ready_out;
   logic [2:0]  wb_mux_sel_in;
   logic [31:0] alu_result_in;
   logic [31:0] imm_in;
   logic [31:0] csr_data_in;
   logic [31:0] pc_plus_4_in;
   logic [4:0]  rd_addr_in;
   logic        rf_wr_en_in;
   logic [1:0]  load_size_in;
   logic        load_unsigned_in;
   logic [31:0] dmem_rdata_in;
   logic        dmem_rvalid_in;
   logic [31:0] rd_out;
   logic [4:0]  rd_addr_out;
   logic        wr_en_out;
   logic        stall_out;
   logic        load_misaligned_out;

   wr_t sb[$];
   int  n_cmp = 0;
   int  n_err = 0;

   msrv32_wb_stage dut (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst),
      .ex_valid_in          (ex_valid_in),
      .ex_ready_out         (ex_ready_out),
      .wb_mux_sel_in        (wb_mux_sel_in),
      .alu_result_in        (alu_result_in),
      .imm_in               (imm_in),
      .csr_data_in          (csr_data_in),
      .pc_plus_4_in         (pc_plus_4_in),
      .rd_addr_in           (rd_addr_in),
      .rf_wr_en_in          (rf_wr_en_in),
      .load_size_in         (load_size_in),
      .load_unsigned_in     (load_unsigned_in),
      .dmem_rdata_in        (dmem_rdata_in),
      .dmem_rvalid_in       (dmem_rvalid_in),
      .rd_out               (rd_out),
      .rd_addr_out          (rd_addr_out),
      .wr_en_out            (wr_en_out),
      .stall_out            (stall_out),
      .load_misaligned_out  (load_misaligned_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Every retired write is matched against the oldest expected write
   always @(negedge clk)
      if (wr_en_out === 1'b1) begin
         if (sb.size() == 0)
            chk("wr_unexpected", 32'd1, 32'd0);
         else begin
            wr_t e;
            e = sb.pop_front();
            chk("wr_data", rd_out, e.data);
            chk("wr_addr", {27'd0, rd_addr_out}, {27'd0, e.addr});
         end
      end

   task automatic issue(input logic [2:0] sel, input logic [31:0] val, input logic [4:0] rd,
                        input logic we, input logic [1:0] size = LOAD_SIZE_WORD, input logic uns = 1'b0);
      ex_valid_in   = 1'b1;
      wb_mux_sel_in = sel;
      alu_result_in = $urandom;
      imm_in        = $urandom;
      csr_data_in   = $urandom;
      pc_plus_4_in  = $urandom;
      case (sel)
         3'd2:    imm_in        = val;
         3'd3:    csr_data_in   = val;
         3'd4:    pc_plus_4_in  = val;
         default: alu_result_in = val;
      endcase
      rd_addr_in       = rd;
      rf_wr_en_in      = we;
      load_size_in     = size;
      load_unsigned_in = uns;
      if (sel != 3'd1 && we && rd != 5'd0) sb.push_back('{val, rd});
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                          input logic [4:0] rd, input logic [31:0] rdata, input int n, input logic [31:0] exp);
      issue(WB_SEL_LOAD, addr, rd, 1'b1, size, uns);
      ex_valid_in = 1'b0;
      if (rd != 5'd0) sb.push_back('{exp, rd});
      for (int i = 0; i < n; i++) begin
         dmem_rdata_in  = rdata;
         dmem_rvalid_in = (i == n - 1);
         @(negedge clk);
         chk("ld_stall", {31'd0, stall_out}, 32'd1);
         chk("ld_early_we", {31'd0, wr_en_out}, 32'd0);
         chk("ld_no_mis", {31'd0, load_misaligned_out}, 32'd0);
         @(posedge clk);
         #1;
      end
      dmem_rvalid_in = 1'b0;
      @(negedge clk);
      chk("ld_ready", {31'd0, ex_ready_out}, 32'd1);
   endtask

   task automatic mis_load(input logic [31:0] addr, input logic [1:0] size);
      issue(WB_SEL_LOAD, addr, 5'd14, 1'b1, size, 1'b0);
      ex_valid_in = 1'b0;
      @(negedge clk);
      chk("mis_pulse", {31'd0, load_misaligned_out}, 32'd1);
      chk("mis_ready", {31'd0, ex_ready_out}, 32'd1);
      chk("mis_we", {31'd0, wr_en_out}, 32'd0);
      @(negedge clk);
      chk("mis_clear", {31'd0, load_misaligned_out}, 32'd0);
      chk("mis_ready2", {31'd0, ex_ready_out}, 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      ex_valid_in = 1'b0; wb_mux_sel_in = '0; alu_result_in = '0; imm_in = '0;
      csr_data_in = '0; pc_plus_4_in = '0; rd_addr_in = '0; rf_wr_en_in = 1'b0;
      load_size_in = '0; load_unsigned_in = 1'b0; dmem_rdata_in = '0; dmem_rvalid_in = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rd", rd_out, 32'd0);
      chk("rst_addr", {27'd0, rd_addr_out}, 32'd0);
      chk("rst_we", {31'd0, wr_en_out}, 32'd0);
      chk("rst_mis", {31'd0, load_misaligned_out}, 32'd0);
      chk("rst_ready", {31'd0, ex_ready_out}, 32'd1);
      chk("rst_stall", {31'd0, stall_out}, 32'd0);
      rst = 1'b0;
      // Reset while waiting for load data aborts the load
      issue(WB_SEL_LOAD, 32'h1000, 5'd7, 1'b1, LOAD_SIZE_WORD, 1'b0);
      ex_valid_in = 1'b0;
      @(negedge clk);
      chk("abort_stall_pre", {31'd0, stall_out}, 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_ready", {31'd0, ex_ready_out}, 32'd1);
      chk("abort_stall", {31'd0, stall_out}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dmem_rdata_in  = 32'hDEADBEEF;
      dmem_rvalid_in = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("abort_we", {31'd0, wr_en_out}, 32'd0);
         chk("abort_ready_after", {31'd0, ex_ready_out}, 32'd1);
      end
      dmem_rvalid_in = 1'b0;
      // Back-to-back non-load sources, rd=0 and non-writing instructions
      issue(WB_SEL_ALU, 32'h12345678, 5'd5, 1'b1);
      issue(WB_SEL_PC4, 32'h00000104, 5'd1, 1'b1);
      issue(WB_SEL_IMM, 32'hABCDE000, 5'd2, 1'b1);
      issue(WB_SEL_CSR, 32'h5A5A5A5A, 5'd3, 1'b1);
      issue(3'd6, 32'h0BADF00D, 5'd31, 1'b1);
      issue(WB_SEL_ALU, 32'h11111111, 5'd0, 1'b1);
      issue(WB_SEL_ALU, 32'h22222222, 5'd9, 1'b0);
      ex_valid_in = 1'b0;
      @(negedge clk);
      chk("hold_we", {31'd0, wr_en_out}, 32'd0);
      chk("hold_rd", rd_out, 32'h0BADF00D);
      chk("hold_addr", {27'd0, rd_addr_out}, 32'd31);
      chk("b2b_ready", {31'd0, ex_ready_out}, 32'd1);
      // Loads of each size and extension
      do_load(32'h1003, LOAD_SIZE_BYTE, 1'b0, 5'd10, 32'h80AABBCC, 3, 32'hFFFFFF80);
      do_load(32'h1003, LOAD_SIZE_BYTE, 1'b1, 5'd11, 32'h80AABBCC, 3, 32'h00000080);
      do_load(32'h2002, LOAD_SIZE_HALF, 1'b0, 5'd13, 32'h9ABC1234, 1, 32'hFFFF9ABC);
      do_load(32'h2000, LOAD_SIZE_HALF, 1'b1, 5'd15, 32'h9ABC8234, 2, 32'h00008234);
      do_load(32'h3001, LOAD_SIZE_BYTE, 1'b0, 5'd16, 32'h00007F00, 1, 32'h0000007F);
      do_load(32'h3000, LOAD_SIZE_WORD, 1'b0, 5'd17, 32'hCAFEBABE, 2, 32'hCAFEBABE);
      do_load(32'h3004, 2'b11, 1'b0, 5'd18, 32'h13579BDF, 1, 32'h13579BDF);
      do_load(32'h3008, LOAD_SIZE_WORD, 1'b0, 5'd0, 32'hFFFFFFFF, 1, 32'h0);
      // Instruction presented during the wait is taken only after the load retires
      issue(WB_SEL_LOAD, 32'h4002, 5'd20, 1'b1, LOAD_SIZE_BYTE, 1'b0);
      sb.push_back('{32'hFFFFFFA5, 5'd20});
      wb_mux_sel_in = WB_SEL_ALU;
      alu_result_in = 32'h00000077;
      rd_addr_in    = 5'd12;
      rf_wr_en_in   = 1'b1;
      sb.push_back('{32'h00000077, 5'd12});
      for (int i = 0; i < 3; i++) begin
         dmem_rdata_in  = 32'h00A50000;
         dmem_rvalid_in = (i == 2);
         @(negedge clk);
         chk("held_stall", {31'd0, stall_out}, 32'd1);
         @(posedge clk);
         #1;
      end
      dmem_rvalid_in = 1'b0;
      @(posedge clk);
      #1;
      ex_valid_in = 1'b0;
      @(negedge clk);
      // Misaligned loads
      mis_load(32'h2001, LOAD_SIZE_WORD);
      mis_load(32'h2003, LOAD_SIZE_HALF);
      mis_load(32'h2002, 2'b11);
      dmem_rvalid_in = 1'b1;
      @(negedge clk);
      dmem_rvalid_in = 1'b0;
      repeat (2) @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
